multi_clk_divider: RTL

- Multi-channel programmable clock divider and clock-enable generator.
- Each channel produces a divided square wave and a one-cycle terminal-count tick. Consumers are OLED, audio and display timing logic.
- Divisors change at run time through a valid/ready load port. A new divisor takes effect only at the channel's next terminal count, so no output shows a runt period.
- A global restart aligns the phase of all channels.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 92 +++++++++
 rtl/multi_clk_divider.sv | 76 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//
// Contents:
//   DIV_W_DEFAULT - default divisor / counter width
//   div_word_t    - divisor word at the default width
//   ch_idx_width  - width of a channel index for n channels, at least 1 bit
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef logic [DIV_W_DEFAULT-1:0] div_word_t;

    // A single channel still needs a 1-bit index port, so the width is never 0.
    function automatic int ch_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel. It holds the running counter, the active divisor and
// one staged (pending) divisor.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        run enable, level-sensitive
//   i_restart   one-cycle pulse that phase-aligns the channel
//   i_load_stb  accepted load for this channel (the top has already qualified it)
//   i_load_div  divisor M to stage; the half-period is M+1 cycles
//   o_clk_out   divided square wave, registered
//   o_tick      one-cycle pulse on each terminal count, registered
//   o_pend      a staged divisor is waiting to be applied
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic             i_load_stb,
    input  logic [DIV_W-1:0] i_load_div,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pend
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;

    logic w_hold;
    logic w_terminal;

    // Restart wins over enable and over the terminal count.
    assign w_hold     = i_restart | ~i_en;
    assign w_terminal = (r_cnt == r_div_active);

    // r_div_active changes only while the counter is being forced to 0
    // (hold or terminal). So r_cnt never passes r_div_active and the
    // increment cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_div_active <= RESET_DIV;
            r_div_pend   <= '0;
            r_pend       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            if (w_hold) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                if (r_pend) begin
                    r_div_active <= r_div_pend;
                end
            end else if (w_terminal) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
                if (r_pend) begin
                    r_div_active <= r_div_pend;
                end
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end

            // A load is accepted only while r_pend is clear, so it never
            // competes with an apply in the same cycle. A value accepted on a
            // terminal cycle therefore waits for the following terminal.
            if (i_load_stb) begin
                r_div_pend <= i_load_div;
                r_pend     <= 1'b1;
            end else if (w_hold || w_terminal) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider and clock-enable generator.
// Each channel drives a 50% duty square wave with period 2*(M+1) and a
// one-cycle tick on each terminal count. A new divisor is staged and takes
// effect at the channel's next terminal count, so no output shows a runt
// period.
//
// Ports:
//   CLOCK       system clock, rising edge
//   RESET_N     asynchronous active-low reset
//   ch_en       per-channel run enable
//   restart     one-cycle pulse; zeroes every channel and applies staged divisors
//   load_valid  divisor load request
//   load_ch     target channel of the load
//   load_div    new divisor M
//   load_ready  channel can accept a load
//   clk_out     divided square wave per channel
//   tick        terminal-count pulse per channel
//   pending     a divisor is staged per channel
//
// Load handshake: a transfer happens on the rising edge where
// load_valid && load_ready. load_ready is combinational from the selected
// channel's pending flag and load_ch. It is low for a busy channel and for
// load_ch >= NUM_CH. The requester holds load_valid, load_ch and load_div
// stable until the transfer completes. A request made while load_ready is
// low is simply not taken.
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int        NUM_CH      = 4,
    parameter int        DIV_W       = DIV_W_DEFAULT,
    parameter div_word_t DEFAULT_DIV = '0,
    localparam int       CH_W        = ch_idx_width(NUM_CH)
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              restart,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DIV_W-1:0]  load_div,
    output logic              load_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_stb;

    // One-hot decode of load_ch. An index with no channel selects nothing,
    // so load_ready stays low and the request is dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_sel[g] = (load_ch == CH_W'(g));
        assign w_stb[g] = load_valid & w_sel[g] & ~w_pend[g];

        clk_div_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DIV_W'(DEFAULT_DIV))
        ) u_ch (
            .i_clk      (CLOCK),
            .i_rst_n    (RESET_N),
            .i_en       (ch_en[g]),
            .i_restart  (restart),
            .i_load_stb (w_stb[g]),
            .i_load_div (load_div),
            .o_clk_out  (clk_out[g]),
            .o_tick     (tick[g]),
            .o_pend     (w_pend[g])
        );
    end

    assign load_ready = |(w_sel & ~w_pend);
    assign pending    = w_pend;

endmodule
